// File: rtl/bowling_pkg.sv
// Shared state encoding and game constants for the bowling frame sequencer.
package bowling_pkg;

  typedef enum logic [1:0] {
    ST_ROLL1 = 2'd0,
    ST_ROLL2 = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] NUM_FRAMES = 4'd10;
  localparam logic [3:0] MAX_PINS   = 4'd10;
  localparam int         SCORE_W    = 9;

endpackage

// File: rtl/bowling_bonus_slots.sv
// Two pending-bonus counters; each busy slot adds one extra pin multiple to the next rolls.
module bonus_slots
  import bowling_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       adv_i,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  output logic [1:0] mult_o
);

  logic [1:0] cnt_a_q, cnt_a_d;
  logic [1:0] cnt_b_q, cnt_b_d;
  logic [1:0] a_dec, b_dec;

  assign mult_o = 2'd1 + {1'b0, (cnt_a_q != 2'd0)} + {1'b0, (cnt_b_q != 2'd0)};

  always_comb begin
    a_dec   = (adv_i && cnt_a_q != 2'd0) ? cnt_a_q - 2'd1 : cnt_a_q;
    b_dec   = (adv_i && cnt_b_q != 2'd0) ? cnt_b_q - 2'd1 : cnt_b_q;
    cnt_a_d = a_dec;
    cnt_b_d = b_dec;
    // A new bonus goes into whichever slot is free after this roll's decrement.
    if (load_i) begin
      if (a_dec == 2'd0) cnt_a_d = load_val_i;
      else               cnt_b_d = load_val_i;
    end
    if (clr_i) begin
      cnt_a_d = 2'd0;
      cnt_b_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_a_q <= 2'd0;
      cnt_b_q <= 2'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

endmodule

// File: rtl/bowling_frame_ctrl.sv
// Bowling game sequencer: frame/roll/pin tracking, strike/spare bonus and running total.
//   state    | meaning
//   ST_ROLL1 | waiting for first ball of a frame
//   ST_ROLL2 | waiting for second ball of a frame
//   ST_FILL  | waiting for the frame-10 fill ball
//   ST_DONE  | game over; only new_game or reset leaves
module bowling_frame_ctrl
  import bowling_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               new_game,
  input  logic               roll_valid,
  input  logic [3:0]         roll_pins,
  output logic               roll_ready,
  output logic [3:0]         frame_num,
  output logic [1:0]         roll_num,
  output logic [3:0]         pins_standing,
  output logic [SCORE_W-1:0] total_score,
  output logic               roll_err,
  output logic               game_over
);

  state_e             state_q, state_d;
  logic [3:0]         frame_q, frame_d;
  logic [1:0]         roll_q, roll_d;
  logic [3:0]         standing_q, standing_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               err_q, err_d;
  logic               strike10_q, strike10_d;

  logic       bonus_clr, bonus_adv, bonus_load;
  logic [1:0] bonus_val, mult;
  logic [4:0] prod;
  logic       accept, last_frame, clear_rack;
  logic [3:0] left;

  bonus_slots u_bonus (
    .clk_i      (CLOCK_50),
    .rst_ni     (reset_n),
    .clr_i      (bonus_clr),
    .adv_i      (bonus_adv),
    .load_i     (bonus_load),
    .load_val_i (bonus_val),
    .mult_o     (mult)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    roll_d     = roll_q;
    standing_d = standing_q;
    score_d    = score_q;
    err_d      = 1'b0;
    strike10_d = strike10_q;
    bonus_clr  = 1'b0;
    bonus_adv  = 1'b0;
    bonus_load = 1'b0;
    bonus_val  = 2'd0;

    accept     = roll_valid && (state_q != ST_DONE);
    last_frame = (frame_q == NUM_FRAMES);
    clear_rack = (roll_pins == standing_q);
    left       = standing_q - roll_pins;
    prod       = {1'b0, roll_pins} * {3'b000, mult};

    if (new_game) begin
      state_d    = ST_ROLL1;
      frame_d    = 4'd1;
      roll_d     = 2'd1;
      standing_d = MAX_PINS;
      score_d    = '0;
      strike10_d = 1'b0;
      bonus_clr  = 1'b1;
    end else if (accept) begin
      if (roll_pins > standing_q) begin
        err_d = 1'b1;
      end else begin
        bonus_adv  = 1'b1;
        score_d    = score_q + SCORE_W'(prod);
        standing_d = clear_rack ? MAX_PINS : left;
        unique case (state_q)
          ST_ROLL1: begin
            state_d = ST_ROLL2;
            roll_d  = 2'd2;
            if (last_frame) begin
              strike10_d = clear_rack;
            end else if (clear_rack) begin
              state_d    = ST_ROLL1;
              roll_d     = 2'd1;
              frame_d    = frame_q + 4'd1;
              bonus_load = 1'b1;
              bonus_val  = 2'd2;
            end
          end
          ST_ROLL2: begin
            if (!last_frame) begin
              state_d    = ST_ROLL1;
              roll_d     = 2'd1;
              frame_d    = frame_q + 4'd1;
              standing_d = MAX_PINS;
              bonus_load = clear_rack;
              bonus_val  = 2'd1;
            end else if (strike10_q || clear_rack) begin
              state_d = ST_FILL;
              roll_d  = 2'd3;
            end else begin
              state_d = ST_DONE;
            end
          end
          ST_FILL:  state_d = ST_DONE;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ROLL1;
      frame_q    <= 4'd1;
      roll_q     <= 2'd1;
      standing_q <= MAX_PINS;
      score_q    <= '0;
      err_q      <= 1'b0;
      strike10_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      roll_q     <= roll_d;
      standing_q <= standing_d;
      score_q    <= score_d;
      err_q      <= err_d;
      strike10_q <= strike10_d;
    end
  end

  assign roll_ready    = (state_q != ST_DONE);
  assign game_over     = (state_q == ST_DONE);
  assign frame_num     = frame_q;
  assign roll_num      = roll_q;
  assign pins_standing = standing_q;
  assign total_score   = score_q;
  assign roll_err      = err_q;

endmodule

// File: tb/tb_bowling_frame_ctrl.sv
// Scoreboard bench for bowling_frame_ctrl against a roll-history scoring model.
module tb_bowling_frame_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       new_game = 1'b0;
  logic       roll_valid = 1'b0;
  logic [3:0] roll_pins = 4'd0;
  logic       roll_ready;
  logic [3:0] frame_num;
  logic [1:0] roll_num;
  logic [3:0] pins_standing;
  logic [8:0] total_score;
  logic       roll_err;
  logic       game_over;

  bowling_frame_ctrl dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .new_game      (new_game),
    .roll_valid    (roll_valid),
    .roll_pins     (roll_pins),
    .roll_ready    (roll_ready),
    .frame_num     (frame_num),
    .roll_num      (roll_num),
    .pins_standing (pins_standing),
    .total_score   (total_score),
    .roll_err      (roll_err),
    .game_over     (game_over)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int frame;
    int roll;
    int stand;
    int score;
    int err;
    int ready;
    int over;
  } exp_t;

  exp_t expq[$];
  int   hist[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(string nm, int act, int expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int nxt(int j);
    return (j < hist.size()) ? hist[j] : 0;
  endfunction

  // Derives the whole visible game state from the list of accepted rolls using bowling rules.
  task automatic model_eval(output int fr, output int rl, output int st, output int sc, output bit dn);
    int n, idx, a, b, k, s2;
    n = hist.size(); idx = 0;
    fr = 1; rl = 1; st = 10; sc = 0; dn = 0;
    for (int f = 1; f <= 9; f++) begin
      fr = f; rl = 1; st = 10;
      if (idx >= n) return;
      a = hist[idx];
      if (a == 10) begin
        sc += 10 + nxt(idx + 1) + nxt(idx + 2);
        idx += 1;
      end else if (idx + 1 >= n) begin
        rl = 2; st = 10 - a; sc += a;
        return;
      end else begin
        b = hist[idx + 1];
        sc += a + b;
        if (a + b == 10) sc += nxt(idx + 2);
        idx += 2;
      end
    end
    fr = 10; rl = 1; st = 10; k = n - idx;
    for (int j = idx; j < n; j++) sc += hist[j];
    if (k == 0) return;
    a = hist[idx];
    if (k == 1) begin
      rl = 2; st = (a == 10) ? 10 : 10 - a;
      return;
    end
    b  = hist[idx + 1];
    s2 = (a == 10) ? ((b == 10) ? 10 : 10 - b) : ((a + b == 10) ? 10 : 10 - a - b);
    if (k == 2) begin
      st = s2;
      if (a == 10 || a + b == 10) rl = 3;
      else begin rl = 2; dn = 1; end
      return;
    end
    dn = 1; rl = 3;
    st = (hist[idx + 2] == s2) ? 10 : s2 - hist[idx + 2];
  endtask

  task automatic push_exp(int err);
    exp_t e;
    int fr, rl, st, sc;
    bit dn;
    model_eval(fr, rl, st, sc, dn);
    e.frame = fr; e.roll = rl; e.stand = st; e.score = sc;
    e.err = err; e.ready = dn ? 0 : 1; e.over = dn ? 1 : 0;
    expq.push_back(e);
  endtask

  task automatic offer(int pins, bit ng);
    int fr, rl, st, sc;
    bit dn;
    int err;
    @(negedge CLOCK_50);
    roll_valid = 1'b1;
    roll_pins  = pins[3:0];
    new_game   = ng;
    err = 0;
    if (ng) begin
      hist.delete();
    end else begin
      model_eval(fr, rl, st, sc, dn);
      if (!dn) begin
        if (pins > st) err = 1;
        else hist.push_back(pins);
      end
    end
    push_exp(err);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      roll_valid = 1'b0;
      new_game   = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    idle(2);
    while (expq.size() > 0 && t < 50) begin
      @(negedge CLOCK_50);
      t++;
    end
    n_checks++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_frame"}, frame_num, 1);
    chk({tag, "_roll"}, roll_num, 1);
    chk({tag, "_stand"}, pins_standing, 10);
    chk({tag, "_score"}, total_score, 0);
    chk({tag, "_err"}, roll_err, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_ready"}, roll_ready, 1);
  endtask

  // Monitor: any cycle with an offered roll or new_game yields registered outputs one edge later.
  initial begin
    bit   off;
    exp_t e;
    forever begin
      @(posedge CLOCK_50);
      off = (roll_valid || new_game) && reset_n;
      @(negedge CLOCK_50);
      if (off) begin
        if (expq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL scoreboard_empty: got output expected none pending");
        end else begin
          e = expq.pop_front();
          chk("frame_num", frame_num, e.frame);
          chk("roll_num", roll_num, e.roll);
          chk("pins_standing", pins_standing, e.stand);
          chk("total_score", total_score, e.score);
          chk("roll_err", roll_err, e.err);
          chk("roll_ready", roll_ready, e.ready);
          chk("game_over", game_over, e.over);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, rl, st, sc, p, guard;
    bit dn;
    #12;
    chk_reset_state("rst");
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    idle(1);

    // Gutter game
    repeat (20) offer(0, 0);
    offer(5, 0);
    drain();
    chk("gutter_total", total_score, 0);
    chk("gutter_frame", frame_num, 10);
    chk("gutter_ready", roll_ready, 0);
    chk("gutter_over", game_over, 1);

    // Perfect game plus one ignored roll
    offer(0, 1);
    repeat (12) offer(10, 0);
    offer(10, 0);
    drain();
    chk("perfect_total", total_score, 300);
    chk("perfect_err", roll_err, 0);

    // All spares 5/5 with fill 5
    offer(0, 1);
    repeat (21) offer(5, 0);
    drain();
    chk("spares_total", total_score, 150);

    // Illegal second ball
    offer(0, 1);
    offer(7, 0);
    offer(4, 0);
    offer(3, 0);
    drain();
    chk("illegal_total", total_score, 10);

    // Strike, spare, open
    offer(0, 1);
    offer(10, 0); offer(7, 0); offer(3, 0); offer(9, 0); offer(0, 0);
    drain();
    chk("mixed_total", total_score, 48);
    chk("mixed_frame", frame_num, 4);

    // new_game with simultaneous roll in frame 5
    offer(0, 1);
    repeat (8) offer(4, 0);
    offer(6, 1);
    drain();
    chk_reset_state("ng");

    // Async reset mid-roll
    offer(3, 0); offer(2, 0); offer(10, 0);
    drain();
    @(negedge CLOCK_50);
    roll_valid = 1'b1;
    roll_pins  = 4'd4;
    #2 reset_n = 1'b0;
    #1 chk_reset_state("async");
    @(negedge CLOCK_50);
    roll_valid = 1'b0;
    hist.delete();
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    idle(1);

    // Random games including illegal offers and idle gaps
    repeat (6) begin
      offer(0, 1);
      guard = 0;
      while (guard < 40) begin
        model_eval(fr, rl, st, sc, dn);
        if (dn) break;
        if ($urandom_range(7) == 0) p = st + 1 + int'($urandom_range(14 - st));
        else p = int'($urandom_range(st));
        offer(p, 0);
        if ($urandom_range(5) == 0) idle(1);
        guard++;
      end
      offer(int'($urandom_range(10)), 0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
